sw_result_collector: RTL and testbench

//  Gathers alignment results from N_PE Smith-Waterman processing elements and writes them, one per cycle max,

---
 rtl/sw_result_collector_pkg.sv | 34 +++
 rtl/sw_result_collector_if.sv | 40 ++++
 rtl/sw_result_collector_rr_arbiter.sv | 56 +++++
 rtl/sw_result_collector.sv | 126 ++++++++++++
 tb/tb_sw_result_collector.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_result_collector_pkg.sv
// -----------------------------------------------------------------------------
// sw_result_collector_pkg
//   Shared constants and record layout for the Smith-Waterman result path.
//   The fifo instantiation and the host-side unpacker use the same definitions.
//   Record layout (OUT_W bits): {pe index tag, opaque PE payload}.
// -----------------------------------------------------------------------------
package sw_result_collector_pkg;

  localparam int SW_N_PE     = 8;
  localparam int SW_OUT_W    = 48;
  localparam int SW_IDX_BITS = 8;
  localparam int SW_DATA_BITS = SW_OUT_W - SW_IDX_BITS;
  localparam int SW_CNT_BITS = 32;

  // Field offsets inside a fifo word.
  localparam int SW_DATA_LSB = 0;
  localparam int SW_DATA_MSB = SW_DATA_BITS - 1;
  localparam int SW_IDX_LSB  = SW_DATA_BITS;
  localparam int SW_IDX_MSB  = SW_OUT_W - 1;

  typedef struct packed {
    logic [SW_IDX_BITS-1:0]  idx;
    logic [SW_DATA_BITS-1:0] data;
  } sw_record_t;

  function automatic sw_record_t sw_make_record(input logic [SW_IDX_BITS-1:0]  idx,
                                                input logic [SW_DATA_BITS-1:0] data);
    sw_record_t rec;
    rec.idx  = idx;
    rec.data = data;
    return rec;
  endfunction

endpackage

// File: rtl/sw_result_collector_if.sv
// -----------------------------------------------------------------------------
// sw_result_collector_if
//   Bundles the PE result handshake and the fifo write port.
//   Vector ordering: PE0 occupies the most significant bit of res_vld/res_ack
//   and the most significant DATA_BITS slice of res_data.
//   master : environment side (PEs and fifo) - drives res_vld, res_data, fifo_full
//   slave  : collector side - drives res_ack, fifo_we, fifo_data
// -----------------------------------------------------------------------------
interface sw_result_collector_if #(
  parameter int N_PE      = 8,
  parameter int DATA_BITS = 40,
  parameter int OUT_W     = 48
);

  logic [N_PE-1:0]           res_vld;
  logic [N_PE*DATA_BITS-1:0] res_data;
  logic [N_PE-1:0]           res_ack;
  logic                      fifo_full;
  logic                      fifo_we;
  logic [OUT_W-1:0]          fifo_data;

  modport master (
    output res_vld,
    output res_data,
    output fifo_full,
    input  res_ack,
    input  fifo_we,
    input  fifo_data
  );

  modport slave (
    input  res_vld,
    input  res_data,
    input  fifo_full,
    output res_ack,
    output fifo_we,
    output fifo_data
  );

endinterface

// File: rtl/sw_result_collector_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sw_rr_arbiter
//   Purely combinational round-robin arbiter: rotate requests so that bit 0 is
//   the pointer position, priority-encode the lowest set bit, then add the
//   pointer back (mod N). Works for any N, power of two or not.
//   req     in  N      request vector, bit i = requester i
//   ptr     in  PTR_W  highest-priority requester this cycle (must be < N)
//   gnt     out N      one-hot grant, zero when no request
//   gnt_idx out PTR_W  index of granted requester (0 when none)
//   any     out 1      at least one request present
// -----------------------------------------------------------------------------
module sw_rr_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  localparam logic [PTR_W:0] N_EXT   = (PTR_W+1)'(N);
  localparam logic [N-1:0]   ONE_HOT = {{(N-1){1'b0}}, 1'b1};

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     rotated;
  logic [PTR_W-1:0] enc_k;
  logic [PTR_W:0]   idx_sum;

  // Doubling the vector turns the rotate into a plain right shift.
  assign req_dbl = {req, req};
  assign rotated = N'(req_dbl >> ptr);
  assign any     = |req;

  always_comb begin
    enc_k = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        enc_k = PTR_W'(k);
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, ptr} + {1'b0, enc_k};
    if (idx_sum >= N_EXT) begin
      gnt_idx = PTR_W'(idx_sum - N_EXT);
    end else begin
      gnt_idx = PTR_W'(idx_sum);
    end
  end

  assign gnt = any ? (ONE_HOT << gnt_idx) : '0;

endmodule

// File: rtl/sw_result_collector.sv
// -----------------------------------------------------------------------------
// sw_result_collector
//   Collects results from N_PE Smith-Waterman PEs round-robin, tags each with
//   its PE index and writes at most one record per cycle into the result fifo.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   bus      slave modport of sw_result_collector_if:
//              res_vld/res_data in, res_ack out (combinational, one-hot or 0),
//              fifo_full in, fifo_we/fifo_data out
//   res_cnt  out  records written to the fifo, wraps modulo 2^CNT_BITS
//   idle     out  no PE request and nothing held
// -----------------------------------------------------------------------------
module sw_result_collector
  import sw_result_collector_pkg::*;
#(
  parameter int N_PE      = SW_N_PE,
  parameter int OUT_W     = SW_OUT_W,
  parameter int IDX_BITS  = SW_IDX_BITS,
  parameter int DATA_BITS = SW_DATA_BITS,
  parameter int CNT_BITS  = SW_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  sw_result_collector_if.slave bus,
  output logic [CNT_BITS-1:0]  res_cnt,
  output logic                 idle
);

  localparam int PTR_W = (N_PE > 1) ? $clog2(N_PE) : 1;

  // Elaboration-time parameter sanity.
  if (N_PE < 2 || N_PE > 256) begin : g_bad_n_pe
    $error("sw_result_collector: N_PE must be in 2..256");
  end
  if (N_PE > (1 << IDX_BITS)) begin : g_bad_idx_bits
    $error("sw_result_collector: IDX_BITS too narrow for N_PE");
  end
  if (OUT_W != IDX_BITS + DATA_BITS) begin : g_bad_out_w
    $error("sw_result_collector: OUT_W must equal IDX_BITS + DATA_BITS");
  end

  logic                 hold_vld_reg, hold_vld_next;
  logic [IDX_BITS-1:0]  hold_idx_reg, hold_idx_next;
  logic [DATA_BITS-1:0] hold_data_reg, hold_data_next;
  logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CNT_BITS-1:0]  res_cnt_reg, res_cnt_next;

  logic [N_PE-1:0]      pe_vld;
  logic [N_PE-1:0]      pe_gnt;
  logic [DATA_BITS-1:0] pe_data [N_PE];
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 fifo_we;
  logic                 ld;
  logic                 grant_en;
  logic                 take;

  // Port vectors put PE0 in the most significant position; internally PE i
  // lives at index i.
  genvar gi;
  for (gi = 0; gi < N_PE; gi++) begin : g_pe
    assign pe_vld[gi]                = bus.res_vld[N_PE-1-gi];
    assign pe_data[gi]               = bus.res_data[(N_PE-1-gi)*DATA_BITS +: DATA_BITS];
    assign bus.res_ack[N_PE-1-gi]    = pe_gnt[gi] & grant_en;
  end

  sw_rr_arbiter #(
    .N     (N_PE),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (pe_vld),
    .ptr     (rr_ptr_reg),
    .gnt     (pe_gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // fifo_full only rises the cycle after a write, so writing whenever it is
  // low can never overrun a slot.
  assign fifo_we  = hold_vld_reg & ~bus.fifo_full;
  // Loading while the hold drains keeps one record per cycle sustained.
  assign ld       = ~hold_vld_reg | fifo_we;
  // While reset is asserted the empty hold would otherwise look loadable;
  // suppress acks so no PE believes a result was taken.
  assign grant_en = ld & rst;
  assign take     = grant_en & gnt_any;

  always_comb begin
    hold_vld_next  = hold_vld_reg & ~fifo_we;
    hold_idx_next  = hold_idx_reg;
    hold_data_next = hold_data_reg;
    rr_ptr_next    = rr_ptr_reg;
    res_cnt_next   = res_cnt_reg;
    if (take) begin
      hold_vld_next  = 1'b1;
      hold_idx_next  = IDX_BITS'(gnt_idx);
      hold_data_next = pe_data[gnt_idx];
      rr_ptr_next    = (gnt_idx == PTR_W'(N_PE - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (fifo_we) begin
      res_cnt_next = res_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld_reg  <= 1'b0;
      hold_idx_reg  <= '0;
      hold_data_reg <= '0;
      rr_ptr_reg    <= '0;
      res_cnt_reg   <= '0;
    end else begin
      hold_vld_reg  <= hold_vld_next;
      hold_idx_reg  <= hold_idx_next;
      hold_data_reg <= hold_data_next;
      rr_ptr_reg    <= rr_ptr_next;
      res_cnt_reg   <= res_cnt_next;
    end
  end

  assign bus.fifo_we   = fifo_we;
  assign bus.fifo_data = {hold_idx_reg, hold_data_reg};
  assign res_cnt       = res_cnt_reg;
  assign idle          = ~hold_vld_reg & ~|bus.res_vld;

endmodule

// File: tb/tb_sw_result_collector.sv
// -----------------------------------------------------------------------------
// tb_sw_result_collector
//   Directed bench for sw_result_collector. A second instance with a 4-bit
//   result counter sees identical stimulus to exercise counter wrap.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge (or mid-cycle for the asynchronous reset pulse).
// -----------------------------------------------------------------------------
module tb_sw_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] res_cnt;
  logic        idle;
  logic [3:0]  res_cnt4;
  logic        idle4;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  sw_result_collector_if #(.N_PE(8), .DATA_BITS(40), .OUT_W(48)) bus ();
  sw_result_collector_if #(.N_PE(8), .DATA_BITS(40), .OUT_W(48)) bus4 ();

  assign bus4.res_vld   = bus.res_vld;
  assign bus4.res_data  = bus.res_data;
  assign bus4.fifo_full = bus.fifo_full;

  sw_result_collector #(.N_PE(8), .OUT_W(48), .IDX_BITS(8), .DATA_BITS(40), .CNT_BITS(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .res_cnt (res_cnt),
    .idle    (idle)
  );

  sw_result_collector #(.N_PE(8), .OUT_W(48), .IDX_BITS(8), .DATA_BITS(40), .CNT_BITS(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus4),
    .res_cnt (res_cnt4),
    .idle    (idle4)
  );

  function automatic logic [7:0] pe_bit(input int i);
    return 8'h80 >> i;
  endfunction

  task automatic set_data(input int i, input logic [39:0] d);
    bus.res_data[(7-i)*40 +: 40] = d;
  endtask

  task automatic at_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    at_drive();
    rst           = 1'b0;
    bus.res_vld   = 8'h00;
    bus.fifo_full = 1'b0;
    bus.res_data  = '0;
    at_drive();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.res_vld   = 8'hFF;
    bus.fifo_full = 1'b0;
    bus.res_data  = '0;
    set_data(0, 40'hA0_0000_0001);
    at_drive();
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h00) begin err_cnt++; $display("FAIL rst_ack: got %h want %h", bus.res_ack, 8'h00); end
    vec_cnt++; if (bus.fifo_we !== 1'b0) begin err_cnt++; $display("FAIL rst_we: got %b want 0", bus.fifo_we); end
    vec_cnt++; if (res_cnt !== 32'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d want 0", res_cnt); end
    vec_cnt++; if (bus.fifo_data !== 48'h0) begin err_cnt++; $display("FAIL rst_data: got %h want 0", bus.fifo_data); end
    vec_cnt++; if (idle !== 1'b0) begin err_cnt++; $display("FAIL rst_idle: got %b want 0", idle); end
    at_drive();
    rst = 1'b1;
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h80) begin err_cnt++; $display("FAIL release_ack: got %h want 80", bus.res_ack); end
    at_drive();
    bus.res_vld = 8'h00;
    at_sample();
    vec_cnt++; if (bus.fifo_we !== 1'b1) begin err_cnt++; $display("FAIL release_we: got %b want 1", bus.fifo_we); end
    vec_cnt++; if (bus.fifo_data !== 48'h00_A0_0000_0001) begin err_cnt++; $display("FAIL release_data: got %h want 00a000000001", bus.fifo_data); end
    at_drive();
    at_sample();
    vec_cnt++; if (bus.fifo_we !== 1'b0) begin err_cnt++; $display("FAIL release_we_off: got %b want 0", bus.fifo_we); end
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL release_idle: got %b want 1", idle); end
    vec_cnt++; if (res_cnt !== 32'd1) begin err_cnt++; $display("FAIL release_cnt: got %0d want 1", res_cnt); end
    $display("test_reset: done, %0d miscompares so far", err_cnt);
  endtask

  task automatic test_single_pe();
    apply_reset();
    bus.res_vld = 8'h10;
    set_data(3, 40'h12_3456_789A);
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h10) begin err_cnt++; $display("FAIL pe3_ack: got %h want 10", bus.res_ack); end
    vec_cnt++; if (bus.fifo_we !== 1'b0) begin err_cnt++; $display("FAIL pe3_we_early: got %b want 0", bus.fifo_we); end
    at_drive();
    bus.res_vld = 8'h00;
    at_sample();
    vec_cnt++; if (bus.fifo_we !== 1'b1) begin err_cnt++; $display("FAIL pe3_we: got %b want 1", bus.fifo_we); end
    vec_cnt++; if (bus.fifo_data !== 48'h03_12_3456_789A) begin err_cnt++; $display("FAIL pe3_data: got %h want 03123456789a", bus.fifo_data); end
    vec_cnt++; if (bus.res_ack !== 8'h00) begin err_cnt++; $display("FAIL pe3_ack_off: got %h want 00", bus.res_ack); end
    at_drive();
    at_sample();
    vec_cnt++; if (res_cnt !== 32'd1) begin err_cnt++; $display("FAIL pe3_cnt: got %0d want 1", res_cnt); end
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL pe3_idle: got %b want 1", idle); end
    $display("test_single_pe: done, %0d miscompares so far", err_cnt);
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp_data;
    apply_reset();
    for (int i = 0; i < 8; i++) set_data(i, 40'hC0_0000_0000 + 40'(i));
    bus.res_vld = 8'hFF;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) at_drive();
      at_sample();
      vec_cnt++; if (bus.res_ack !== pe_bit(c % 8)) begin err_cnt++; $display("FAIL b2b_ack c=%0d: got %h want %h", c, bus.res_ack, pe_bit(c % 8)); end
      if (c > 0) begin
        exp_data = {8'((c - 1) % 8), 40'hC0_0000_0000 + 40'((c - 1) % 8)};
        vec_cnt++; if (bus.fifo_we !== 1'b1) begin err_cnt++; $display("FAIL b2b_we c=%0d: got %b want 1", c, bus.fifo_we); end
        vec_cnt++; if (bus.fifo_data !== exp_data) begin err_cnt++; $display("FAIL b2b_data c=%0d: got %h want %h", c, bus.fifo_data, exp_data); end
      end
      if (c == 16) begin
        vec_cnt++; if (res_cnt4 !== 4'd15) begin err_cnt++; $display("FAIL b2b_cnt4_pre: got %0d want 15", res_cnt4); end
      end
    end
    at_drive();
    bus.res_vld = 8'h00;
    at_sample();
    vec_cnt++; if (res_cnt !== 32'd16) begin err_cnt++; $display("FAIL b2b_cnt: got %0d want 16", res_cnt); end
    vec_cnt++; if (res_cnt4 !== 4'd0) begin err_cnt++; $display("FAIL b2b_cnt4_wrap: got %0d want 0", res_cnt4); end
    vec_cnt++; if (bus.fifo_data !== 48'h00_C0_0000_0000) begin err_cnt++; $display("FAIL b2b_last_data: got %h want 00c000000000", bus.fifo_data); end
    $display("test_back_to_back: done, %0d miscompares so far", err_cnt);
  endtask

  task automatic test_full_stall();
    apply_reset();
    bus.fifo_full = 1'b1;
    set_data(0, 40'h11_1111_1111);
    set_data(1, 40'h22_2222_2222);
    set_data(2, 40'h33_3333_3333);
    bus.res_vld = 8'h80;
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h80) begin err_cnt++; $display("FAIL full_load_ack: got %h want 80", bus.res_ack); end
    at_drive();
    bus.res_vld = 8'h60;
    for (int k = 0; k < 5; k++) begin
      at_sample();
      vec_cnt++; if (bus.fifo_we !== 1'b0) begin err_cnt++; $display("FAIL full_we k=%0d: got %b want 0", k, bus.fifo_we); end
      vec_cnt++; if (bus.res_ack !== 8'h00) begin err_cnt++; $display("FAIL full_ack k=%0d: got %h want 00", k, bus.res_ack); end
      vec_cnt++; if (bus.fifo_data !== 48'h00_11_1111_1111) begin err_cnt++; $display("FAIL full_data k=%0d: got %h want 001111111111", k, bus.fifo_data); end
      at_drive();
    end
    bus.fifo_full = 1'b0;
    at_sample();
    vec_cnt++; if (bus.fifo_we !== 1'b1) begin err_cnt++; $display("FAIL unfull_we: got %b want 1", bus.fifo_we); end
    vec_cnt++; if (bus.res_ack !== 8'h40) begin err_cnt++; $display("FAIL unfull_ack: got %h want 40", bus.res_ack); end
    at_drive();
    bus.res_vld = 8'h20;
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h20) begin err_cnt++; $display("FAIL unfull_ack2: got %h want 20", bus.res_ack); end
    vec_cnt++; if (bus.fifo_data !== 48'h01_22_2222_2222) begin err_cnt++; $display("FAIL unfull_data1: got %h want 012222222222", bus.fifo_data); end
    at_drive();
    bus.res_vld = 8'h00;
    at_sample();
    vec_cnt++; if (bus.fifo_data !== 48'h02_33_3333_3333) begin err_cnt++; $display("FAIL unfull_data2: got %h want 023333333333", bus.fifo_data); end
    vec_cnt++; if (res_cnt !== 32'd2) begin err_cnt++; $display("FAIL unfull_cnt: got %0d want 2", res_cnt); end
    $display("test_full_stall: done, %0d miscompares so far", err_cnt);
  endtask

  task automatic test_fairness();
    apply_reset();
    set_data(5, 40'h55_0000_0005);
    set_data(6, 40'h66_0000_0006);
    set_data(2, 40'h22_0000_0002);
    bus.res_vld = 8'h04;
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h04) begin err_cnt++; $display("FAIL fair_pe5: got %h want 04", bus.res_ack); end
    at_drive();
    bus.res_vld = 8'h22;
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h02) begin err_cnt++; $display("FAIL fair_pe6: got %h want 02", bus.res_ack); end
    vec_cnt++; if (bus.fifo_data !== 48'h05_55_0000_0005) begin err_cnt++; $display("FAIL fair_data5: got %h want 055500000005", bus.fifo_data); end
    at_drive();
    bus.res_vld = 8'h20;
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h20) begin err_cnt++; $display("FAIL fair_pe2: got %h want 20", bus.res_ack); end
    vec_cnt++; if (bus.fifo_data !== 48'h06_66_0000_0006) begin err_cnt++; $display("FAIL fair_data6: got %h want 066600000006", bus.fifo_data); end
    at_drive();
    bus.res_vld = 8'h00;
    at_sample();
    vec_cnt++; if (bus.fifo_data !== 48'h02_22_0000_0002) begin err_cnt++; $display("FAIL fair_data2: got %h want 022200000002", bus.fifo_data); end
    $display("test_fairness: done, %0d miscompares so far", err_cnt);
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 8; i++) set_data(i, 40'hE0_0000_0000 + 40'(i));
    bus.res_vld = 8'hFF;
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h80) begin err_cnt++; $display("FAIL arst_ack0: got %h want 80", bus.res_ack); end
    at_drive();
    at_sample();
    vec_cnt++; if (bus.res_ack !== 8'h40) begin err_cnt++; $display("FAIL arst_ack1: got %h want 40", bus.res_ack); end
    at_drive();
    at_sample();
    vec_cnt++; if (bus.fifo_data !== 48'h01_E0_0000_0001) begin err_cnt++; $display("FAIL arst_pre_data: got %h want 01e000000001", bus.fifo_data); end
    vec_cnt++; if (res_cnt !== 32'd1) begin err_cnt++; $display("FAIL arst_pre_cnt: got %0d want 1", res_cnt); end
    #1 rst = 1'b0;
    #1;
    vec_cnt++; if (bus.fifo_we !== 1'b0) begin err_cnt++; $display("FAIL arst_we: got %b want 0", bus.fifo_we); end
    vec_cnt++; if (bus.res_ack !== 8'h00) begin err_cnt++; $display("FAIL arst_ack: got %h want 00", bus.res_ack); end
    vec_cnt++; if (res_cnt !== 32'd0) begin err_cnt++; $display("FAIL arst_cnt: got %0d want 0", res_cnt); end
    vec_cnt++; if (res_cnt4 !== 4'd0) begin err_cnt++; $display("FAIL arst_cnt4: got %0d want 0", res_cnt4); end
    vec_cnt++; if (bus.fifo_data !== 48'h0) begin err_cnt++; $display("FAIL arst_data: got %h want 0", bus.fifo_data); end
    #1 rst = 1'b1;
    #1;
    vec_cnt++; if (bus.res_ack !== 8'h80) begin err_cnt++; $display("FAIL arst_rel_ack: got %h want 80", bus.res_ack); end
    vec_cnt++; if (bus.fifo_we !== 1'b0) begin err_cnt++; $display("FAIL arst_rel_we: got %b want 0", bus.fifo_we); end
    at_drive();
    at_sample();
    vec_cnt++; if (bus.fifo_we !== 1'b1) begin err_cnt++; $display("FAIL arst_post_we: got %b want 1", bus.fifo_we); end
    vec_cnt++; if (bus.fifo_data !== 48'h00_E0_0000_0000) begin err_cnt++; $display("FAIL arst_post_data: got %h want 00e000000000", bus.fifo_data); end
    at_drive();
    bus.res_vld = 8'h00;
    at_sample();
    vec_cnt++; if (res_cnt !== 32'd1) begin err_cnt++; $display("FAIL arst_post_cnt: got %0d want 1", res_cnt); end
    $display("test_async_reset: done, %0d miscompares so far", err_cnt);
  endtask

  initial begin
    test_reset();
    test_single_pe();
    test_back_to_back();
    test_full_stall();
    test_fairness();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
